// File: rtl/config_pkg.sv
// config_pkg: ternary code constants, engine states and a width-generic saturation helper
package config_pkg;
  typedef logic [1:0] ternary_t;
  localparam ternary_t TERN_ZERO = 2'b00;
  localparam ternary_t TERN_POS = 2'b01;
  localparam ternary_t TERN_NEG = 2'b11;
  localparam ternary_t TERN_ILLEGAL = 2'b10;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} operation_t;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/ternary_row_dot.sv
// ternary_row_dot: exact dot product of one ternary row with x, illegal codes count as zero
module ternary_row_dot
  import config_pkg::*;
#(
  parameter int D = 4,
  parameter int W = 8,
  parameter int A = 11
) (
  input  logic [2*D-1:0]      row,
  input  logic [D*W-1:0]      x,
  output logic signed [A-1:0] acc,
  output logic                illegal
);
  always_comb begin
    acc = '0;
    illegal = 1'b0;
    for (int j = 0; j < D; j++) begin
      acc = row[2*j +: 2] == TERN_POS ? acc + A'($signed(x[W*j +: W])) :
            row[2*j +: 2] == TERN_NEG ? acc - A'($signed(x[W*j +: W])) : acc;
      illegal = illegal | (row[2*j +: 2] == TERN_ILLEGAL);
    end
  end
endmodule

// File: rtl/ternary_mvm_seq.sv
// ternary_mvm_seq: y = sat((W*x*s) >>> FRAC_BITS), LANES rows per cycle behind valid/ready
module ternary_mvm_seq
  import config_pkg::*;
#(
  parameter int D = 4,
  parameter int INT_BITS = 5,
  parameter int FRAC_BITS = 3,
  parameter int LANES = 1,
  localparam int W = INT_BITS + FRAC_BITS,
  localparam int A = W + $clog2(D) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D*W-1:0]   in_vec,
  input  logic [2*D*D-1:0] in_mat,
  input  logic [W-1:0]     in_scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D*W-1:0]   out_vec,
  output logic             out_illegal
);
  localparam int G = D / LANES;
  localparam int CW = G > 1 ? $clog2(G) : 1;
  operation_t state, nxt;
  logic [CW-1:0] cnt;
  logic [D*W-1:0] vec_q;
  logic [2*D*D-1:0] mat_q;
  logic [W-1:0] scale_q;
  logic signed [A-1:0] acc [LANES];
  logic [LANES-1:0] ill;
  logic [W-1:0] y [LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [A+W-1:0] prod;
    ternary_row_dot #(.D(D), .W(W), .A(A)) u_dot (
      .row(mat_q[2*D*(int'(cnt)*LANES+l) +: 2*D]),
      .x(vec_q),
      .acc(acc[l]),
      .illegal(ill[l])
    );
    assign prod = ((A+W)'(acc[l]) * (A+W)'($signed(scale_q))) >>> FRAC_BITS;
    assign y[l] = W'(sat(64'(prod), W));
  end
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (in_valid ? COMPUTE : IDLE) :
          state == COMPUTE ? (cnt == CW'(G - 1) ? DONE : COMPUTE) :
          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_vec <= '0;
      out_illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        vec_q <= in_vec;
        mat_q <= in_mat;
        scale_q <= in_scale;
        cnt <= '0;
        out_illegal <= 1'b0;
      end
      if (state == COMPUTE) begin
        cnt <= cnt + 1'b1;
        out_illegal <= out_illegal | (|ill);
        for (int l = 0; l < LANES; l++) out_vec[W*(int'(cnt)*LANES+l) +: W] <= y[l];
      end
    end
  end
endmodule

// File: tb/tb_ternary_mvm_seq.sv
// tb_ternary_mvm_seq: directed and random requests, queued expectations checked by a monitor
module tb_ternary_mvm_seq;
  parameter int LANES = 1;
  localparam int D = 4, FB = 3, W = 8, DW = D * W, MW = 2 * D * D, G = D / LANES;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_illegal;
  logic [DW-1:0] in_vec = '0, out_vec;
  logic [MW-1:0] in_mat = '0;
  logic [W-1:0] in_scale = '0;
  typedef struct {logic [DW-1:0] v; logic ill; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, passed = 0, cyc = 0, hold = 0;
  bit rnd = 0;
  logic pv = 0, phs = 0, pill = 0;
  logic [DW-1:0] pvec = '0;

  ternary_mvm_seq #(.D(D), .INT_BITS(5), .FRAC_BITS(FB), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_mat(in_mat), .in_scale(in_scale), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, x);
  endtask

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] m = '0;
    for (int r = 0; r < D; r++) m[2*(r*D+r) +: 2] = 2'b01;
    return m;
  endfunction

  // Reference: integer arithmetic straight from y = sat(floor(acc*s / 2^FB))
  function automatic void model(input logic [DW-1:0] v, input logic [MW-1:0] m,
                                input logic [W-1:0] s, output logic [DW-1:0] y, output logic ill);
    int acc, p, x;
    logic [1:0] code;
    ill = 0;
    y = '0;
    for (int r = 0; r < D; r++) begin
      acc = 0;
      for (int c = 0; c < D; c++) begin
        code = m[2*(r*D+c) +: 2];
        x = int'($signed(v[W*c +: W]));
        if (code == 2'b10) ill = 1;
        else if (code == 2'b01) acc += x;
        else if (code == 2'b11) acc -= x;
      end
      p = $rtoi($floor(real'(acc * int'($signed(s))) / real'(1 << FB)));
      p = p > 127 ? 127 : p < -128 ? -128 : p;
      y[W*r +: W] = p[W-1:0];
    end
  endfunction

  task automatic send(input logic [DW-1:0] v, input logic [MW-1:0] m, input logic [W-1:0] s,
                      input logic [DW-1:0] ev, input logic ei);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL in_ready_timeout: in_ready=0 expected 1 within 200 cycles");
      return;
    end
    in_vec = v;
    in_mat = m;
    in_scale = s;
    in_valid = 1;
    @(posedge clk);
    #1;
    q.push_back('{ev, ei, cyc});
    in_valid = 0;
    in_vec = DW'($urandom);
    in_mat = MW'({$urandom, $urandom});
    in_scale = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (hold > 0 && out_valid) begin
      out_ready = 0;
      hold--;
    end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      phs = 0;
    end else begin
      if (phs) chk("in_ready_after_hs", in_ready, 1);
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (!pv) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: out_valid=1 expected 0 (no request pending)");
          end else chk("latency", cyc - q[0].cyc, G);
        end else begin
          chk("hold_vec", out_vec, pvec);
          chk("hold_illegal", out_illegal, pill);
        end
        if (out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("out_vec", out_vec, e.v);
          chk("out_illegal", out_illegal, e.ill);
        end
      end
      phs = out_valid && out_ready;
      pv = out_valid;
      pvec = out_vec;
      pill = out_illegal;
    end
  end

  initial begin
    logic [DW-1:0] v, ey;
    logic [MW-1:0] m;
    logic [W-1:0] s;
    logic ei;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_illegal", out_illegal, 0);
    rst = 0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    send(32'h04E81008, ident(), 8'h08, 32'h04E81008, 0);
    send(32'h7F7F7F7F, {MW/2{2'b01}}, 8'h08, 32'h7F7F7F7F, 0);
    send(32'h7F7F7F7F, {MW/2{2'b11}}, 8'h08, 32'h80808080, 0);
    send(32'h000108FF, ident(), 8'h04, 32'h000004FF, 0);
    send(32'h00001008, 32'h00000006, 8'h08, 32'h00000010, 1);
    drain();
    hold = 6;
    send(32'h04E81008, ident(), 8'h08, 32'h04E81008, 0);
    drain();
    send(32'h04E81008, ident(), 8'h08, 32'h04E81008, 0);
    if (G > 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1;
    chk("in_ready_during_rst", in_ready, 0);
    rst = 0;
    q.delete();
    repeat (8) begin
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_vec", out_vec, 0);
      chk("abort_out_illegal", out_illegal, 0);
    end
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      v = DW'($urandom);
      s = W'($urandom);
      for (int k = 0; k < D * D; k++) begin
        int r = $urandom_range(0, 9);
        m[2*k +: 2] = r == 0 ? 2'b10 : r < 4 ? 2'b00 : r < 7 ? 2'b01 : 2'b11;
      end
      model(v, m, s, ey, ei);
      send(v, m, s, ey, ei);
    end
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
